// File: rtl/diaosi_types_pkg.sv
// Shared types and encodings for the pipeline sequencer.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } pctrl_state_t;

  localparam int PCSRC_W_DEF = 2;
  localparam int ADD4_DIAOSI = 0;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use detect: the EX-stage load writes a register the ID-stage instruction reads.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             d_ren_x,
  input  logic             wen_x,
  input  logic [REG_W-1:0] wsel_x,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  output logic             load_use
);

  // Register zero is hardwired, so a load targeting it never creates a hazard.
  assign load_use = d_ren_x & wen_x & (wsel_x != '0) &
                    ((wsel_x == rs_d) | (wsel_x == rt_d));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: advance enables, flushes, PC write and sticky halt.
// Optional event counters are built when PIPE_CTRL_STATS_EN is defined.
module pipe_ctrl
  import diaosi_types_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int PCSRC_W = PCSRC_W_DEF
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               d_ren_m,
  input  logic               d_wen_m,
  input  logic [PCSRC_W-1:0] PCSrc_m,
  input  logic               halt_m,
  input  logic               d_ren_x,
  input  logic [REG_W-1:0]   wsel_x,
  input  logic               wen_x,
  input  logic [REG_W-1:0]   rs_d,
  input  logic [REG_W-1:0]   rt_d,
  output logic               pc_en,
  output logic               pipe1_en,
  output logic               pipe2_en,
  output logic               pipe3_en,
  output logic               pipe4_en,
  output logic               flushed1,
  output logic               flushed2,
  output logic               flushed3,
  output logic               halt_o
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  pctrl_state_t state;
  logic dreq, frozen, redirect, load_use;
  logic active, act_freeze, act_redirect, act_stall, act_miss, act_run;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .d_ren_x  (d_ren_x),
    .wen_x    (wen_x),
    .wsel_x   (wsel_x),
    .rs_d     (rs_d),
    .rt_d     (rt_d),
    .load_use (load_use)
  );

  assign dreq     = d_ren_m | d_wen_m;
  assign frozen   = dreq & ~dhit;
  assign redirect = (PCSrc_m != PCSRC_W'(ADD4_DIAOSI));

  // Exactly one action is selected per cycle, in priority order.
  assign active       = nRST & (state != HALTED);
  assign act_freeze   = active & frozen;
  assign act_redirect = active & ~frozen & redirect;
  assign act_stall    = active & ~frozen & ~redirect & load_use;
  assign act_miss     = active & ~frozen & ~redirect & ~load_use & ~ihit;
  assign act_run      = active & ~frozen & ~redirect & ~load_use & ihit;

  assign pc_en    = act_redirect | act_run;
  assign pipe1_en = act_redirect | act_miss | act_run;
  assign pipe2_en = act_redirect | act_stall | act_miss | act_run;
  assign pipe3_en = pipe2_en;
  assign pipe4_en = pipe2_en;
  assign flushed1 = act_redirect | act_miss;
  assign flushed2 = act_redirect | act_stall;
  assign flushed3 = act_redirect;

  // A halt reaching MEM is only honoured once any pending data access has completed.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= RUN;
      halt_o <= 1'b0;
    end else if (state != HALTED) begin
      if (halt_m && !frozen) begin
        state  <= HALTED;
        halt_o <= 1'b1;
      end else if (state == RUN && frozen) begin
        state <= DWAIT;
      end else if (state == DWAIT && dhit) begin
        state <= RUN;
      end
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      if (act_stall)             stall_cnt <= stall_cnt + 32'd1;
      if (act_redirect)          flush_cnt <= flush_cnt + 32'd1;
      if (act_freeze | act_miss) miss_cnt  <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl; counter checks are built with PIPE_CTRL_STATS_EN.
module tb_pipe_ctrl;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       ihit = 1'b1, dhit = 1'b0, d_ren_m = 1'b0, d_wen_m = 1'b0;
  logic [1:0] PCSrc_m = 2'd0;
  logic       halt_m = 1'b0, d_ren_x = 1'b0, wen_x = 1'b0;
  logic [4:0] wsel_x = 5'd0, rs_d = 5'd0, rt_d = 5'd0;
  logic       pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en;
  logic       flushed1, flushed2, flushed3, halt_o;
`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_cnt, flush_cnt, miss_cnt;
  logic [31:0] m_stall, m_flush, m_miss;
  bit          stats_live = 1'b1;
`endif

  int total = 0;
  int bad = 0;
  bit m_halted;

  pipe_ctrl #(.REG_W(5), .PCSRC_W(2)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .d_ren_m(d_ren_m), .d_wen_m(d_wen_m), .PCSrc_m(PCSrc_m), .halt_m(halt_m),
    .d_ren_x(d_ren_x), .wsel_x(wsel_x), .wen_x(wen_x), .rs_d(rs_d), .rt_d(rt_d),
    .pc_en(pc_en), .pipe1_en(pipe1_en), .pipe2_en(pipe2_en), .pipe3_en(pipe3_en),
    .pipe4_en(pipe4_en), .flushed1(flushed1), .flushed2(flushed2),
    .flushed3(flushed3), .halt_o(halt_o)
`ifdef PIPE_CTRL_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef enum {C_OFF, C_HALT, C_FREEZE, C_REDIR, C_STALL, C_MISS, C_RUN} cat_t;

  function automatic cat_t classify();
    if (!nRST) return C_OFF;
    if (m_halted) return C_HALT;
    if ((d_ren_m || d_wen_m) && !dhit) return C_FREEZE;
    if (PCSrc_m != 2'd0) return C_REDIR;
    if (d_ren_x && wen_x && wsel_x != 5'd0 && (wsel_x == rs_d || wsel_x == rt_d))
      return C_STALL;
    if (!ihit) return C_MISS;
    return C_RUN;
  endfunction

  // Expected {pc_en, pipe1..4_en, flushed1..3, halt_o} for each kind of cycle.
  function automatic logic [8:0] modelOut();
    case (classify())
      C_HALT:  return 9'b0_0000_000_1;
      C_REDIR: return 9'b1_1111_111_0;
      C_STALL: return 9'b0_0111_010_0;
      C_MISS:  return 9'b0_1111_100_0;
      C_RUN:   return 9'b1_1111_000_0;
      default: return 9'b0_0000_000_0;
    endcase
  endfunction

  function automatic logic [8:0] dutOut();
    return {pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
            flushed1, flushed2, flushed3, halt_o};
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_halted <= 1'b0;
`ifdef PIPE_CTRL_STATS_EN
      m_stall <= '0; m_flush <= '0; m_miss <= '0;
`endif
    end else if (!m_halted) begin
      if (halt_m && classify() != C_FREEZE) m_halted <= 1'b1;
`ifdef PIPE_CTRL_STATS_EN
      if (classify() == C_STALL) m_stall <= m_stall + 32'd1;
      if (classify() == C_REDIR) m_flush <= m_flush + 32'd1;
      if (classify() == C_FREEZE || classify() == C_MISS) m_miss <= m_miss + 32'd1;
`endif
    end
  end

  always @(negedge CLK) begin
    total++;
    if (dutOut() !== modelOut()) begin
      bad++;
      $display("[TB] FAIL cycle_check t=%0t got=%b expected=%b", $time, dutOut(), modelOut());
    end
`ifdef PIPE_CTRL_STATS_EN
    if (stats_live) begin
      total++;
      if ({stall_cnt, flush_cnt, miss_cnt} !== {m_stall, m_flush, m_miss}) begin
        bad++;
        $display("[TB] FAIL cnt_check t=%0t got=%0d/%0d/%0d expected=%0d/%0d/%0d", $time,
                 stall_cnt, flush_cnt, miss_cnt, m_stall, m_flush, m_miss);
      end
    end
`endif
  end

  task automatic applyStimulus(input bit ih, input bit dh, input bit drm, input bit dwm,
                               input logic [1:0] pcs, input bit hm, input bit drx,
                               input logic [4:0] wx, input bit wenx,
                               input logic [4:0] rs, input logic [4:0] rt);
    ihit = ih; dhit = dh; d_ren_m = drm; d_wen_m = dwm; PCSrc_m = pcs; halt_m = hm;
    d_ren_x = drx; wsel_x = wx; wen_x = wenx; rs_d = rs; rt_d = rt;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [8:0] expv);
    total++;
    if (dutOut() !== expv) begin
      bad++;
      $display("[TB] FAIL %s got=%b expected=%b", name, dutOut(), expv);
    end
  endtask

  task automatic checkCount(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_held", 9'b0_0000_000_0);
    repeat (2) tick();
    nRST = 1'b1;
    #1;
    checkOutput("first_run", 9'b1_1111_000_0);
    tick();

    applyStimulus(1, 0, 0, 0, 0, 0, 1, 8, 1, 8, 3);
    checkOutput("load_use_rs", 9'b0_0111_010_0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3);
    checkOutput("load_use_r0", 9'b1_1111_000_0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 9, 1, 4, 9);
    checkOutput("load_use_rt", 9'b0_0111_010_0);
    tick();

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("store_wait", 9'b0_0000_000_0);
      tick();
    end
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("store_done", 9'b1_1111_000_0);
    tick();

    applyStimulus(1, 0, 0, 0, 2, 0, 1, 8, 1, 8, 0);
    checkOutput("redirect_over_lu", 9'b1_1111_111_0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fetch_miss", 9'b0_1111_100_0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("redirect_over_miss", 9'b1_1111_111_0);
    tick();
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("load_same_cycle", 9'b1_1111_000_0);
    tick();

    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    nRST = 1'b0;
    #1;
    checkOutput("reset_mid_dwait", 9'b0_0000_000_0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b1;
    #1;
    checkOutput("after_dwait_reset", 9'b1_1111_000_0);
    tick();

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("halt_deferred", 9'b0_0000_000_0);
      tick();
    end
    applyStimulus(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("halt_release", 9'b1_1111_000_0);
    tick();
    applyStimulus(1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    checkOutput("halted_redirect", 9'b0_0000_000_1);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 1, 1, 8, 1, 8, 8);
    checkOutput("halted_sticky", 9'b0_0000_000_1);
    tick();
    nRST = 1'b0;
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b1;
    #1;
    checkOutput("halt_cleared", 9'b1_1111_000_0);
    tick();

`ifdef PIPE_CTRL_STATS_EN
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 8, 1, 8, 0);
      tick();
    end
    applyStimulus(1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCount("stall_cnt", stall_cnt, 32'd2);
    checkCount("flush_cnt", flush_cnt, 32'd1);
    checkCount("miss_cnt", miss_cnt, 32'd4);
    @(negedge CLK);
    stats_live = 1'b0;
    dut.miss_cnt = 32'hFFFF_FFFF;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCount("miss_wrap", miss_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
